// File: rtl/stream_demux2.sv
// -----------------------------------------------------------------------------
// stream_demux2
//
// Purpose:
//   Routes a packetised valid/ready stream to one of two output ports. The
//   destination comes from `sel` on the head beat of each packet. It then stays
//   locked until the beat carrying in_last has been accepted. Each output port
//   is a single registered entry. A beat accepted at one edge is therefore
//   visible on the target port after that edge. A port whose entry drains while
//   it is refilled still moves one beat per cycle.
//
// Ports:
//   clk                      sole clock, rising edge
//   rst_n                    asynchronous active-low reset
//   sel                      destination select, used on packet head only
//   in_valid / in_ready      upstream handshake
//   in_data  [WIDTH-1:0]     upstream payload
//   in_last                  upstream end-of-packet marker
//   out0_valid / out0_ready  port-0 handshake
//   out0_data / out0_last    port-0 payload and end-of-packet marker
//   out1_*                   same as out0_* for port 1
//   busy                     high while a multi-beat packet is mid-route
//   pkt_cnt0 / pkt_cnt1      16-bit saturating count of packets leaving each
//                            port. These ports exist only when the macro
//                            STREAM_DEMUX2_PKT_COUNT_EN is defined.
//
// Configuration macro: STREAM_DEMUX2_PKT_COUNT_EN
// -----------------------------------------------------------------------------
module stream_demux2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic             busy
`ifdef STREAM_DEMUX2_PKT_COUNT_EN
    ,
    output logic [15:0]      pkt_cnt0,
    output logic [15:0]      pkt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic tgt;      // current target port
    logic accept;   // upstream beat transfers at the next edge

    // Per-port views, indexed by port number
    logic             port_ready [2];
    logic             port_valid [2];
    logic [WIDTH-1:0] port_data  [2];
    logic             port_last  [2];

    assign port_ready[0] = out0_ready;
    assign port_ready[1] = out1_ready;

    // Target selection and upstream handshake. Only the target port's
    // occupancy matters, so a stalled non-target port never blocks input.
    always_comb begin
        case (state_q)
            ROUTE0:  tgt = 1'b0;
            ROUTE1:  tgt = 1'b1;
            default: tgt = sel;
        endcase
        in_ready = rst_n && (!port_valid[tgt] || port_ready[tgt]);
        accept   = in_valid && in_ready;
    end

    // Packet-lock FSM: a head beat without in_last locks onto its port and the
    // accepted last beat releases it. Single-beat packets never leave IDLE.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (in_last) begin
                state_d = IDLE;
            end else begin
                state_d = tgt ? ROUTE1 : ROUTE0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy = (state_q != IDLE);

    // One registered entry per output port
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic PORT = (gi == 1);

        logic             valid_q, valid_d;
        logic [WIDTH-1:0] data_q,  data_d;
        logic             last_q,  last_d;
        logic             pop;
        logic             push;

        always_comb begin
            pop     = valid_q && port_ready[gi];
            push    = accept && (tgt == PORT);
            valid_d = valid_q;
            data_d  = data_q;
            last_d  = last_q;
            if (pop) begin
                valid_d = 1'b0;
            end
            // Refill wins over drain so a drain and refill in the same cycle
            // keeps the entry full and sustains one beat per cycle.
            if (push) begin
                valid_d = 1'b1;
                data_d  = in_data;
                last_d  = in_last;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                last_q  <= 1'b0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                last_q  <= last_d;
            end
        end

        assign port_valid[gi] = valid_q;
        assign port_data[gi]  = data_q;
        assign port_last[gi]  = last_q;
    end

    assign out0_valid = port_valid[0];
    assign out0_data  = port_data[0];
    assign out0_last  = port_last[0];
    assign out1_valid = port_valid[1];
    assign out1_data  = port_data[1];
    assign out1_last  = port_last[1];

`ifdef STREAM_DEMUX2_PKT_COUNT_EN
    logic [15:0] pkt_cnt [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [15:0] cnt_q, cnt_d;

        // Counts packets leaving the port (last beat handed downstream).
        // The count saturates instead of wrapping.
        always_comb begin
            cnt_d = cnt_q;
            if (port_valid[gi] && port_ready[gi] && port_last[gi] && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= 16'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign pkt_cnt[gi] = cnt_q;
    end

    assign pkt_cnt0 = pkt_cnt[0];
    assign pkt_cnt1 = pkt_cnt[1];
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// -----------------------------------------------------------------------------
// tb_stream_demux2
//
// Self-checking bench for stream_demux2 (WIDTH=8). It uses a table of directed
// vectors, hand-written multi-cycle sequences (backpressure, independent
// drain, reset mid-packet, packet counters) and a randomized phase. The
// randomized phase is checked against a queue-based model of the two ports.
// Configuration macro: STREAM_DEMUX2_PKT_COUNT_EN (counter checks).
// -----------------------------------------------------------------------------
module tb_stream_demux2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out0_last;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic       out1_last;
    logic       busy;
`ifdef STREAM_DEMUX2_PKT_COUNT_EN
    logic [15:0] pkt_cnt0;
    logic [15:0] pkt_cnt1;
`endif

    always #5 clk = ~clk;

    stream_demux2 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .busy       (busy)
`ifdef STREAM_DEMUX2_PKT_COUNT_EN
        ,
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
`endif
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Each record holds the inputs for one cycle. It also holds the expected
    // in_ready before the edge and the expected outputs after the edge.
    typedef struct packed {
        logic       sel;
        logic       vld;
        logic [7:0] data;
        logic       last;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic       e_v0;
        logic [7:0] e_d0;
        logic       e_l0;
        logic       e_v1;
        logic [7:0] e_d1;
        logic       e_l1;
        logic       e_busy;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d, input logic l,
                                input logic r0, input logic r1, input logic er,
                                input logic ev0, input logic [7:0] ed0, input logic el0,
                                input logic ev1, input logic [7:0] ed1, input logic el1,
                                input logic eb);
        vec_t x;
        x.sel = s;   x.vld = v;    x.data = d;   x.last = l;
        x.r0 = r0;   x.r1 = r1;    x.e_rdy = er;
        x.e_v0 = ev0; x.e_d0 = ed0; x.e_l0 = el0;
        x.e_v1 = ev1; x.e_d1 = ed1; x.e_l1 = el1;
        x.e_busy = eb;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        sel = v.sel; in_valid = v.vld; in_data = v.data; in_last = v.last;
        out0_ready = v.r0; out1_ready = v.r1;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(v.e_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".out0_valid"}, 64'(out0_valid), 64'(v.e_v0));
        if (v.e_v0) chk({tag, ".out0_beat"}, 64'({out0_last, out0_data}), 64'({v.e_l0, v.e_d0}));
        chk({tag, ".out1_valid"}, 64'(out1_valid), 64'(v.e_v1));
        if (v.e_v1) chk({tag, ".out1_beat"}, 64'({out1_last, out1_data}), 64'({v.e_l1, v.e_d1}));
        chk({tag, ".busy"}, 64'(busy), 64'(v.e_busy));
        $display("[TB] %s sel=%0d vld=%0d data=%02h last=%0d r0=%0d r1=%0d",
                 tag, v.sel, v.vld, v.data, v.last, v.r0, v.r1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".out0_valid"}, 64'(out0_valid), 64'd0);
        chk({tag, ".out1_valid"}, 64'(out1_valid), 64'd0);
        chk({tag, ".in_ready"},   64'(in_ready),   64'd0);
        chk({tag, ".busy"},       64'(busy),       64'd0);
        chk({tag, ".out0_data_last"}, 64'({out0_last, out0_data}), 64'd0);
        chk({tag, ".out1_data_last"}, 64'({out1_last, out1_data}), 64'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tbl [6];

    // Random-phase model: each port is a queue of {last,data} holding at most
    // one entry. A packet stays locked to its port until the accepted last beat.
    logic [8:0] mq0[$];
    logic [8:0] mq1[$];
    logic       open;
    logic       dest;
    logic       tgt;
    logic       e_rdy;
    logic [8:0] b;
`ifdef STREAM_DEMUX2_PKT_COUNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    initial begin
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        #3;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single beat to port 1, then a 4-beat packet locked to port 0
        tbl[0] = mk(1, 1, 8'hA5, 1, 1, 1, 1, 0, 8'h00, 0, 1, 8'hA5, 1, 0);
        tbl[1] = mk(0, 1, 8'h01, 0, 1, 1, 1, 1, 8'h01, 0, 0, 8'h00, 0, 1);
        tbl[2] = mk(1, 1, 8'h02, 0, 1, 1, 1, 1, 8'h02, 0, 0, 8'h00, 0, 1);
        tbl[3] = mk(0, 1, 8'h03, 0, 1, 1, 1, 1, 8'h03, 0, 0, 8'h00, 0, 1);
        tbl[4] = mk(1, 1, 8'h04, 1, 1, 1, 1, 1, 8'h04, 1, 0, 8'h00, 0, 0);
        tbl[5] = mk(1, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 6; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Backpressure on port 0 mid-packet: input stalls and the data is held
        step(mk(0, 1, 8'h10, 0, 0, 1, 1, 1, 8'h10, 0, 0, 8'h00, 0, 1), "bp0");
        for (int i = 0; i < 3; i++)
            step(mk(1, 1, 8'h11, 0, 0, 1, 0, 1, 8'h10, 0, 0, 8'h00, 0, 1), $sformatf("bp_stall%0d", i));
        step(mk(1, 1, 8'h11, 0, 1, 1, 1, 1, 8'h11, 0, 0, 8'h00, 0, 1), "bp1");
        step(mk(0, 1, 8'h12, 0, 1, 1, 1, 1, 8'h12, 0, 0, 8'h00, 0, 1), "bp2");
        step(mk(1, 1, 8'h13, 1, 1, 1, 1, 1, 8'h13, 1, 0, 8'h00, 0, 0), "bp3");
        step(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0), "bp_drain");

        // Port 1 held stalled while a packet flows through port 0
        step(mk(1, 1, 8'h20, 1, 1, 0, 1, 0, 8'h00, 0, 1, 8'h20, 1, 0), "ind0");
        step(mk(0, 1, 8'h30, 0, 1, 0, 1, 1, 8'h30, 0, 1, 8'h20, 1, 1), "ind1");
        step(mk(1, 1, 8'h31, 0, 1, 0, 1, 1, 8'h31, 0, 1, 8'h20, 1, 1), "ind2");
        step(mk(1, 1, 8'h32, 1, 1, 0, 1, 1, 8'h32, 1, 1, 8'h20, 1, 0), "ind3");
        step(mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 1, 8'h20, 1, 0), "ind_blk");
        step(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0), "ind_drain");

        // Reset at beat 2 of a 4-beat packet routed to port 0
        step(mk(0, 1, 8'h40, 0, 1, 1, 1, 1, 8'h40, 0, 0, 8'h00, 0, 1), "rst_b0");
        step(mk(1, 1, 8'h41, 0, 1, 1, 1, 1, 8'h41, 0, 0, 8'h00, 0, 1), "rst_b1");
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h42;
        #1;
        check_reset_state("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        step(mk(1, 1, 8'h50, 1, 1, 1, 1, 0, 8'h00, 0, 1, 8'h50, 1, 0), "rst_head");
        step(mk(1, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0), "rst_drain");

        reset_dut();
`ifdef STREAM_DEMUX2_PKT_COUNT_EN
        // Three packets to port 0 and two to port 1
        step(mk(0, 1, 8'h60, 1, 1, 1, 1, 1, 8'h60, 1, 0, 8'h00, 0, 0), "cnt0");
        step(mk(1, 1, 8'h61, 1, 1, 1, 1, 0, 8'h00, 0, 1, 8'h61, 1, 0), "cnt1");
        step(mk(0, 1, 8'h62, 1, 1, 1, 1, 1, 8'h62, 1, 0, 8'h00, 0, 0), "cnt2");
        step(mk(1, 1, 8'h63, 1, 1, 1, 1, 0, 8'h00, 0, 1, 8'h63, 1, 0), "cnt3");
        step(mk(0, 1, 8'h64, 1, 1, 1, 1, 1, 8'h64, 1, 0, 8'h00, 0, 0), "cnt4");
        step(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0), "cnt_drain");
        chk("pkt_cnt0", 64'(pkt_cnt0), 64'd3);
        chk("pkt_cnt1", 64'(pkt_cnt1), 64'd2);
        cnt0 = 16'd3;
        cnt1 = 16'd2;
`endif

        // Randomized traffic against the queue model
        open = 1'b0;
        dest = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sel        = 1'($urandom);
            in_valid   = ($urandom_range(0, 9) < 7);
            in_data    = 8'($urandom);
            in_last    = ($urandom_range(0, 3) == 0);
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 3) != 0);
            #1;
            tgt   = open ? dest : sel;
            e_rdy = tgt ? (mq1.size() == 0 || out1_ready) : (mq0.size() == 0 || out0_ready);
            chk("rnd.in_ready",   64'(in_ready),   64'(e_rdy));
            chk("rnd.busy",       64'(busy),       64'(open));
            chk("rnd.out0_valid", 64'(out0_valid), 64'(mq0.size() != 0));
            if (mq0.size() != 0) chk("rnd.out0_beat", 64'({out0_last, out0_data}), 64'(mq0[0]));
            chk("rnd.out1_valid", 64'(out1_valid), 64'(mq1.size() != 0));
            if (mq1.size() != 0) chk("rnd.out1_beat", 64'({out1_last, out1_data}), 64'(mq1[0]));
            @(posedge clk);
            if (mq0.size() != 0 && out0_ready) begin
                b = mq0.pop_front();
                $display("[TB] rnd port0 out data=%02h last=%0d", b[7:0], b[8]);
`ifdef STREAM_DEMUX2_PKT_COUNT_EN
                if (b[8] && cnt0 != 16'hFFFF) cnt0 = cnt0 + 16'd1;
`endif
            end
            if (mq1.size() != 0 && out1_ready) begin
                b = mq1.pop_front();
                $display("[TB] rnd port1 out data=%02h last=%0d", b[7:0], b[8]);
`ifdef STREAM_DEMUX2_PKT_COUNT_EN
                if (b[8] && cnt1 != 16'hFFFF) cnt1 = cnt1 + 16'd1;
`endif
            end
            if (in_valid && e_rdy) begin
                if (tgt) mq1.push_back({in_last, in_data});
                else     mq0.push_back({in_last, in_data});
                open = !in_last;
                dest = tgt;
            end
        end
`ifdef STREAM_DEMUX2_PKT_COUNT_EN
        #1;
        chk("rnd.pkt_cnt0", 64'(pkt_cnt0), 64'(cnt0));
        chk("rnd.pkt_cnt1", 64'(pkt_cnt1), 64'(cnt1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
